ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs,
//  0xFF reset, 0xF4 enable) to the keyboard over the shared open-collector PS2_CLK/PS2_DAT lines.
//  Runs the inhibit / request-to-send sequence, shifts data, parity and stop bits on device clock edges,
//  and checks the device ack. Sits beside the keyboard receiver.
//  busy tells the receiver to ignore line activity during a transmit.
// PARAMETERS
//  INHIBIT_CYCLES  5000    clk cycles PS2_CLK held low before request (100 us @ 50 MHz)
//  START_HOLD      16      clk cycles both lines held low before PS2_CLK is released
//  TIMEOUT_CYCLES  750000  watchdog from end of START_HOLD to end of frame (15 ms @ 50 MHz)
//  FILTER_LEN      8       consecutive equal samples needed to change the filtered PS2_CLK
// PORTS
//  clk                 in   1  50 MHz system clock
//  reset               in   1  synchronous, active-high reset
//  tx_data             in   8  byte to send
//  tx_valid            in   1  request; accepted when tx_valid && tx_ready
//  tx_ready            out  1  high only in IDLE
//  busy                out  1  ~tx_ready
//  tx_done             out  1  1-cycle pulse: frame acked and lines returned idle
//  tx_error            out  1  1-cycle pulse: no ack or watchdog timeout
//  ps2_clk_in          in   1  raw PS2_CLK line level
//  ps2_dat_in          in   1  raw PS2_DAT line level
//  ps2_clk_drive_low   out  1  1 = pull PS2_CLK low; 0 = release (top level maps 0 to 'z')
//  ps2_dat_drive_low   out  1  1 = pull PS2_DAT low; 0 = release
// BEHAVIOUR
//  - Reset: state IDLE. tx_ready=1, busy=0, tx_done=0, tx_error=0.
//    Both drive_low=0. Filter shift reg all ones, filtered clk=1. Counters=0.
//  - Inputs: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchroniser.
//  - Clock filter: filtered clk goes 0 after FILTER_LEN consecutive synced 0s, and 1 after
//    FILTER_LEN consecutive 1s. fall = 1-cycle pulse on the filtered 1->0 transition.
//  - Accept: tx_valid && tx_ready latches tx_data and parity = ~^tx_data (odd parity).
//    Next cycle: INHIBIT, tx_ready=0. tx_valid while busy is ignored; there is no queue.
//  - INHIBIT: clk_drive_low=1, dat_drive_low=0 for exactly INHIBIT_CYCLES cycles, then START.
//  - START: clk_drive_low=1, dat_drive_low=1 (start bit) for START_HOLD cycles.
//    Then SEND: clk_drive_low=0. Watchdog counter clears and starts.
//  - SEND, bit index n=0..9: on each fall, the host presents bit n until the next fall.
//    Bits are tx_data[0]..tx_data[7], then parity, then stop.
//    dat_drive_low = ~bit; the stop bit always releases (dat_drive_low=0).
//    The start bit is held until the 1st fall.
//  - ACK: on the 11th fall, sample the synced data. 0 = acked, 1 = nack.
//    dat_drive_low stays 0. Go to WAIT_IDLE.
//  - WAIT_IDLE: wait until filtered clk=1 and synced data=1, then go to IDLE.
//    In the same cycle pulse tx_done if acked, else tx_error.
//  - Watchdog: runs in SEND/ACK/WAIT_IDLE. When it reaches TIMEOUT_CYCLES:
//    release both lines, pulse tx_error, go to IDLE.
//  - tx_done and tx_error never assert together. tx_ready rises the cycle after either pulse.
//  - Reset mid-frame: the lines are released at the next clk edge and no done/error pulse is issued.
//  - A fall during INHIBIT/START (device still clocking) is ignored. The inhibit count is not restarted.
// TESTING
//  - reset asserted mid-SEND -> both drive_low=0 next edge, tx_ready=1, no tx_done/tx_error.
//  - tx_data=0xED + device model (40 us half-period) -> device samples start 0;
//    data 1,0,1,1,0,1,1,1; parity 1; stop 1. Model acks -> one tx_done, tx_error=0.
//  - tx_data=0xF4 -> parity bit 0. Model acks -> tx_done.
//    Check clk_drive_low was high for exactly INHIBIT_CYCLES+START_HOLD cycles.
//  - tx_data=0x00 (parity 1), model releases data on the ack clock -> tx_error pulse, no tx_done.
//  - No device clocking -> tx_error exactly TIMEOUT_CYCLES after clk release. Lines released, tx_ready=1.
//  - tx_valid held high through a frame with a new tx_data -> only the first byte is sent.
//    A second frame starts only after tx_ready returns.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, bit shifting on filtered
// device clock falls, ack sampling and a watchdog, driving open-collector pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);
  localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t                state_q, state_d;
  logic                  clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q;
  logic                  filt_clk_q, filt_clk_d;
  logic                  fall;
  logic [7:0]            data_q;
  logic                  parity_q;
  logic [3:0]            fall_cnt_q;
  logic [3:0]            bit_idx;
  logic [CNT_W-1:0]      cnt_q;
  logic                  acked_q;
  logic [9:0]            frame;
  logic                  wd_active, wd_expired, line_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_sr_q  <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      filt_sr_q  <= {filt_sr_q[FILTER_LEN-2:0], clk_sync_q};
      filt_clk_q <= filt_clk_d;
    end
  end

  // The filtered clock only flips once the whole history window agrees.
  always_comb begin
    filt_clk_d = filt_clk_q;
    if (&filt_sr_q) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_sr_q) begin
      filt_clk_d = 1'b0;
    end
  end

  assign fall       = filt_clk_q & ~filt_clk_d;
  assign frame      = {1'b1, parity_q, data_q};
  assign bit_idx    = fall_cnt_q - 4'd1;
  assign line_idle  = filt_clk_q & dat_sync_q;
  assign wd_active  = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign wd_expired = wd_active && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = ~tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (tx_valid) state_d = S_INHIBIT;
      S_INHIBIT:   if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) state_d = S_START;
      S_START:     if (cnt_q == CNT_W'(START_HOLD - 1)) state_d = S_SEND;
      S_SEND: begin
        if (wd_expired) state_d = S_IDLE;
        else if (fall && fall_cnt_q == 4'd9) state_d = S_ACK;
      end
      S_ACK: begin
        if (wd_expired) state_d = S_IDLE;
        else if (fall) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: if (wd_expired || line_idle) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // One counter times inhibit, start hold and then the watchdog across SEND..WAIT_IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      parity_q   <= 1'b0;
      fall_cnt_q <= '0;
      cnt_q      <= '0;
      acked_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && tx_valid) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
      end
      if (state_q == S_IDLE ||
          (state_d != state_q && (state_d == S_START || state_d == S_SEND))) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q != S_SEND) begin
        fall_cnt_q <= '0;
      end else if (fall) begin
        fall_cnt_q <= fall_cnt_q + 4'd1;
      end
      if (state_q == S_ACK && fall) begin
        acked_q <= ~dat_sync_q;
      end
    end
  end

  always_comb begin
    ps2_clk_drive_low = 1'b0;
    ps2_dat_drive_low = 1'b0;
    tx_done           = 1'b0;
    tx_error          = 1'b0;
    case (state_q)
      S_INHIBIT: ps2_clk_drive_low = 1'b1;
      S_START: begin
        ps2_clk_drive_low = 1'b1;
        ps2_dat_drive_low = 1'b1;
      end
      S_SEND:    ps2_dat_drive_low = (fall_cnt_q == 4'd0) ? 1'b1 : ~frame[bit_idx];
      S_WAIT_IDLE: begin
        if (line_idle) begin
          tx_done  = acked_q;
          tx_error = ~acked_q;
        end
      end
      default: ;
    endcase
    if (wd_expired) begin
      ps2_clk_drive_low = 1'b0;
      ps2_dat_drive_low = 1'b0;
      tx_done           = 1'b0;
      tx_error          = 1'b1;
    end
    if (reset) begin
      tx_done  = 1'b0;
      tx_error = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model, behavioural PS/2 device,
// cycle-offset timing model of the host sequence and a byte scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int SH  = 16;
  localparam int TO  = 4000;
  localparam int FL  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_drive_low, ps2_dat_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_drive_low | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD    (SH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .busy             (busy),
    .tx_done          (tx_done),
    .tx_error         (tx_error),
    .ps2_clk_in       (ps2_clk_in),
    .ps2_dat_in       (ps2_dat_in),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_dat_drive_low(ps2_dat_drive_low)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         ends = 0;
  int         exp_kind = 1;   // 1 = ack/done, 2 = nack/error, 3 = watchdog error
  logic [7:0] sent_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: everything is expressed as an offset from the accept cycle.
  int k = 0;
  int acc_k = 0;
  int low_run = 0;
  bit open_f = 1'b0;
  bit ended_f = 1'b0;
  bit rst_prev = 1'b0;

  always @(negedge clk) begin
    int off;
    k++;
    if (rst_prev) begin
      chk("rst_clk_dl", ps2_clk_drive_low, 0);
      chk("rst_dat_dl", ps2_dat_drive_low, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_error, 0);
    end
    rst_prev = reset;
    if (reset) begin
      open_f  = 1'b0;
      ended_f = 1'b0;
      low_run = 0;
    end else begin
      chk("busy_inv", busy, !tx_ready);
      if (tx_done || tx_error) chk("pulse_exclusive", tx_done && tx_error, 0);
      if (ps2_clk_drive_low) begin
        low_run++;
      end else if (low_run != 0) begin
        chk("clk_low_len", low_run, INH + SH);
        low_run = 0;
      end
      if (open_f) begin
        off = k - acc_k;
        if (ended_f) begin
          chk("ready_after_end", tx_ready, 1);
          chk("clk_dl_after_end", ps2_clk_drive_low, 0);
          chk("dat_dl_after_end", ps2_dat_drive_low, 0);
          open_f = 1'b0;
        end else if (off <= INH + SH) begin
          chk("clk_dl_hold", ps2_clk_drive_low, 1);
          chk("dat_dl_phase", ps2_dat_drive_low, off > INH);
          chk("ready_low", tx_ready, 0);
          chk("no_early_pulse", tx_done || tx_error, 0);
        end else begin
          chk("clk_dl_released", ps2_clk_drive_low, 0);
          chk("ready_low_send", tx_ready, 0);
          if (exp_kind == 3) begin
            chk("wd_error_time", tx_error, off == INH + SH + 1 + TO);
            chk("wd_no_done", tx_done, 0);
          end else if (tx_done || tx_error) begin
            chk("done_kind", tx_done, exp_kind == 1);
            chk("err_kind", tx_error, exp_kind == 2);
          end
          if (tx_done || tx_error) begin
            ended_f = 1'b1;
            ends++;
          end
        end
      end else begin
        chk("idle_ready", tx_ready, 1);
        chk("idle_clk_dl", ps2_clk_drive_low, 0);
        chk("idle_dat_dl", ps2_dat_drive_low, 0);
        chk("idle_done", tx_done, 0);
        chk("idle_err", tx_error, 0);
      end
      if (!open_f && tx_valid && tx_ready) begin
        open_f  = 1'b1;
        ended_f = 1'b0;
        acc_k   = k;
        sent_q.push_back(tx_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] d, input bit hold);
    int g = 0;
    while (!tx_ready && g < 10000) begin
      cyc(1);
      g++;
    end
    if (!tx_ready) chk("ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    cyc(1);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_end(input int tgt);
    int g = 0;
    while (ends < tgt && g < 3 * TO) begin
      cyc(1);
      g++;
    end
    if (ends < tgt) chk("frame_end", ends, tgt);
  endtask

  // Device: waits for request-to-send, clocks 11 pulses, samples the line while the
  // clock is high before each fall, and drives the ack during the 11th low phase.
  task automatic device(input int hp, input bit ack, output logic [10:0] got);
    int         g = 0;
    logic [7:0] b;
    got = '0;
    while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) && g < INH + SH + 100) begin
      cyc(1);
      g++;
    end
    if (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0)) begin
      chk("device_rts", {ps2_clk_in, ps2_dat_in}, 2'b10);
      return;
    end
    for (int j = 0; j < 11; j++) begin
      cyc(hp);
      got[j]      = ps2_dat_in;
      dev_clk_low = 1'b1;
      if (j == 10) dev_dat_low = ack;
      cyc(hp);
      dev_clk_low = 1'b0;
    end
    cyc(hp);
    dev_dat_low = 1'b0;
    if (sent_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      b = sent_q.pop_front();
      chk("frame_bits", got, {1'b1, ~^b, b, 1'b0});
    end
  endtask

  initial begin
    logic [10:0] got;
    logic [7:0]  d, junk;
    int          tgt, hp, g;
    bit          ack;

    cyc(5);
    reset = 1'b0;
    cyc(3);

    // 0xED acked: start 0, data LSB first, parity 1, stop 1
    exp_kind = 1; tgt = ends + 1;
    start_frame(8'hED, 1'b0);
    device(40, 1'b1, got);
    chk("ed_literal", got, 11'h7DA);
    wait_end(tgt);
    $display("frame 0xED ack -> device saw 0x%03h", got);

    // 0xF4 acked: parity bit 0
    exp_kind = 1; tgt = ends + 1;
    start_frame(8'hF4, 1'b0);
    device(40, 1'b1, got);
    chk("f4_literal", got, 11'h5E8);
    chk("f4_parity", got[9], 1'b0);
    wait_end(tgt);
    $display("frame 0xF4 ack -> device saw 0x%03h", got);

    // 0x00 with no ack: error pulse only
    exp_kind = 2; tgt = ends + 1;
    start_frame(8'h00, 1'b0);
    device(40, 1'b0, got);
    chk("00_literal", got, 11'h600);
    wait_end(tgt);
    $display("frame 0x00 nack -> device saw 0x%03h", got);

    // no device clocking: watchdog error
    exp_kind = 3; tgt = ends + 1;
    start_frame(8'h5A, 1'b0);
    wait_end(tgt);
    if (sent_q.size() > 0) junk = sent_q.pop_front();
    cyc(2);
    chk("to_ready", tx_ready, 1);
    $display("frame 0x5A no device -> watchdog");

    // reset mid-SEND
    exp_kind = 3;
    start_frame(8'h3C, 1'b0);
    cyc(INH + SH + 100);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    if (sent_q.size() > 0) junk = sent_q.pop_front();
    chk("rst_mid_ready", tx_ready, 1);
    $display("frame 0x3C reset mid-send");

    // tx_valid held with a changed byte: second frame only after ready returns
    exp_kind = 1; tgt = ends + 1;
    start_frame(8'hA5, 1'b1);
    tx_data = 8'h5A;
    chk("hold_busy", tx_ready, 0);
    device(30, 1'b1, got);
    chk("hold_first_byte", got[8:1], 8'hA5);
    wait_end(tgt);
    g = 0;
    while (tx_ready && g < 4) begin
      cyc(1);
      g++;
    end
    chk("hold_second_accept", tx_ready, 0);
    tx_valid = 1'b0;
    tgt = ends + 1;
    device(30, 1'b1, got);
    chk("hold_second_byte", got[8:1], 8'h5A);
    wait_end(tgt);
    $display("held valid -> frames 0xA5 then 0x5A");

    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom);
      hp  = $urandom_range(16, 60);
      ack = ($urandom_range(0, 3) != 0);
      exp_kind = ack ? 1 : 2;
      tgt = ends + 1;
      cyc($urandom_range(0, 20));
      start_frame(d, 1'b0);
      device(hp, ack, got);
      wait_end(tgt);
      $display("random frame %0d data 0x%02h hp %0d ack %0d -> device saw 0x%03h",
               i, d, hp, ack, got);
    end

    cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
